// File: rtl/demux_pkg.sv
// Shared constants for the buffered 1-to-2 demultiplexer and its FIFOs.
package demux_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int DEPTH_DEF = 2;
  localparam int CNT_W_DEF = 16;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO, power-of-2 depth, registered head (no push-to-pop bypass).
module fifo_sync
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit tells full from empty when the indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/demux_buffered.sv
// Routes one input word per cycle to one of two FIFO-backed output channels by in_sel.
module demux_buffered
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic full0, full1;
  logic empty0, empty1;
  logic push0, push1;

  // Readiness looks only at the selected FIFO's full flag, so a same-cycle pop never lets a word through.
  assign in_ready   = (in_sel == CH1) ? !full1 : !full0;
  assign push0      = in_valid && in_ready && (in_sel == CH0);
  assign push1      = in_valid && in_ready && (in_sel == CH1);
  assign out0_valid = !empty0;
  assign out1_valid = !empty1;

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push0),
    .wdata (in_data),
    .pop   (out0_ready),
    .full  (full0),
    .empty (empty0),
    .head  (out0_data)
  );

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push1),
    .wdata (in_data),
    .pop   (out1_ready),
    .full  (full1),
    .empty (empty1),
    .head  (out1_data)
  );

  // Debug counters wrap silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (push0) cnt0 <= cnt0 + CNT_W'(1);
      if (push1) cnt1 <= cnt1 + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux_buffered.sv
// Scoreboard bench for demux_buffered: driver issues directed and random words, a negedge monitor checks.
module tb_demux_buffered;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [CNT_W-1:0] mcnt0;
  logic [CNT_W-1:0] mcnt1;

  demux_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT (t=%0t)", name, $time);
  endtask

  // Monitor: compares the DUT against the queue model, then records this cycle's handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", in_ready, (in_sel ? q1.size() : q0.size()) != DEPTH);
      check("out0_valid", out0_valid, q0.size() != 0);
      check("out1_valid", out1_valid, q1.size() != 0);
      check("cnt0", cnt0, mcnt0);
      check("cnt1", cnt1, mcnt1);
      if (out0_valid && out0_ready) begin
        if (q0.size() == 0) check("ch0 unexpected pop", 1, 0);
        else check("ch0 data", out0_data, q0.pop_front());
      end
      if (out1_valid && out1_ready) begin
        if (q1.size() == 0) check("ch1 unexpected pop", 1, 0);
        else check("ch1 data", out1_data, q1.pop_front());
      end
      if (in_valid && in_ready) begin
        if (in_sel) begin q1.push_back(in_data); mcnt1 = mcnt1 + 1'b1; end
        else        begin q0.push_back(in_data); mcnt0 = mcnt0 + 1'b1; end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  task automatic flush_model();
    q0.delete();
    q1.delete();
    mcnt0 = '0;
    mcnt1 = '0;
  endtask

  // Push one word, holding it until the DUT accepts it or the budget expires.
  task automatic push_word(input logic s, input logic [WIDTH-1:0] d, input bit rnd_ready);
    bit done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      drive(1'b1, s, d);
      if (rnd_ready) begin
        out0_ready = 1'($urandom_range(0, 1));
        out1_ready = 1'($urandom_range(0, 1));
      end
      #1;
      done = in_ready;
      tick();
    end
    if (!done) timeout("push_word");
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    drive(1'b0, 1'b0, '0);
    flush_model();
    #3;
    check("reset out0_valid", out0_valid, 0);
    check("reset out1_valid", out1_valid, 0);
    check("reset cnt0", cnt0, 0);
    check("reset in_ready", in_ready, 1);
    #9 rst_n = 1'b1;
    tick();

    // Routing with both consumers ready.
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive(1'b1, 1'b0, 32'hDEADBEEF);
    tick();
    drive(1'b1, 1'b1, 32'h12345678);
    #1;
    check("route out0_valid", out0_valid, 1);
    check("route out0_data", out0_data, 32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b0, '0);
    #1;
    check("route out1_valid", out1_valid, 1);
    check("route out1_data", out1_data, 32'h12345678);
    tick();
    check("route cnt0", cnt0, 1);
    check("route cnt1", cnt1, 1);

    // Backpressure on channel 0 while channel 1 keeps flowing.
    out0_ready = 1'b0;
    drive(1'b1, 1'b0, 32'hA0A0_0001);
    #1 check("full first in_ready", in_ready, 1);
    tick();
    drive(1'b1, 1'b0, 32'hA0A0_0002);
    #1 check("full second in_ready", in_ready, 1);
    tick();
    drive(1'b1, 1'b0, 32'hA0A0_0003);
    #1 check("full third in_ready", in_ready, 0);
    drive(1'b1, 1'b1, 32'hB1B1_0001);
    #1 check("full other ch in_ready", in_ready, 1);
    tick();
    drive(1'b1, 1'b0, 32'hA0A0_0003);
    out0_ready = 1'b1;
    #1 check("full no passthrough", in_ready, 0);
    tick();
    check("full reopen in_ready", in_ready, 1);
    tick();
    drive(1'b0, 1'b0, '0);
    repeat (4) tick();

    // Simultaneous push and pop on channel 1 with one word held.
    out1_ready = 1'b0;
    drive(1'b1, 1'b1, 32'hC0DE_0001);
    tick();
    drive(1'b1, 1'b1, 32'hC0DE_0002);
    out1_ready = 1'b1;
    tick();
    drive(1'b0, 1'b0, '0);
    out1_ready = 1'b0;
    #1;
    check("pushpop out1_valid", out1_valid, 1);
    check("pushpop out1_data", out1_data, 32'hC0DE_0002);
    tick();
    out1_ready = 1'b1;
    tick();
    check("pushpop drained", out1_valid, 0);

    // Asynchronous reset mid-stream with two words held in channel 0.
    out0_ready = 1'b0;
    drive(1'b1, 1'b0, 32'hFEED_0001);
    tick();
    drive(1'b1, 1'b0, 32'hFEED_0002);
    tick();
    drive(1'b0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    check("midreset out0_valid", out0_valid, 0);
    check("midreset cnt0", cnt0, 0);
    check("midreset in_ready", in_ready, 1);
    flush_model();
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("postreset out0_valid", out0_valid, 0);

    // Counter wrap: 17 pushes into a 4-bit counter leaves 1.
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int i = 0; i < 17; i++) push_word(1'b0, 32'h5000_0000 + i, 1'b0);
    tick();
    check("wrap cnt0", cnt0, 1);
    check("wrap cnt1", cnt1, 0);

    // Random stream with random routing and consumer stalls.
    for (int i = 0; i < 1000; i++) push_word(1'($urandom_range(0, 1)), $urandom(), 1'b1);

    out0_ready = 1'b1;
    out1_ready = 1'b1;
    for (int c = 0; c < 50 && (q0.size() != 0 || q1.size() != 0); c++) tick();
    tick();
    check("drain q0 empty", q0.size(), 0);
    check("drain q1 empty", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
